// File: rtl/key_event_gen_pkg.sv
// Shared event encodings and sizing helpers for the key event generator.
package key_event_pkg;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'b00,
      EVT_PRESS   = 2'b01,
      EVT_RELEASE = 2'b10,
      EVT_HOLD    = 2'b11
   } evt_type_e;

   localparam int EVT_TYPE_W = 2;

   // ceil(log2(n)) with a floor of one bit, so a single-key build still has a key field.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   function automatic int evt_rec_w(input int n_keys);
      return clog2_min1(n_keys) + EVT_TYPE_W;
   endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Event stream towards the rhythm-judgement logic plus the sticky overflow status.
interface key_event_gen_if #(
   parameter int KEY_W = 2
);
   logic             evt_valid;
   logic             evt_ready;
   logic [KEY_W-1:0] evt_key;
   logic [1:0]       evt_type;
   logic             overflow;
   logic             clr_overflow;

   modport master (
      output evt_valid, evt_key, evt_type, overflow,
      input  evt_ready, clr_overflow
   );

   modport slave (
      input  evt_valid, evt_key, evt_type, overflow,
      output evt_ready, clr_overflow
   );
endinterface

// File: rtl/key_event_gen_fifo.sv
// Small synchronous event queue; the head entry is read straight out of the storage array.
module event_fifo
   import key_event_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // The extra pointer bit separates a wrapped (full) queue from an empty one.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced key levels into a queued PRESS/HOLD/RELEASE event stream.
module key_event_gen
   import key_event_pkg::*;
#(
   parameter int N_KEYS      = 4,
   parameter int HOLD_CYCLES = 50000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] pbreg,
   key_event_gen_if.master   evt
);
   localparam int KEY_W = clog2_min1(N_KEYS);
   localparam int REC_W = evt_rec_w(N_KEYS);
   localparam int CNT_W = clog2_min1(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(HOLD_CYCLES - 1);

   logic [N_KEYS-1:0] prev;
   logic [N_KEYS-1:0] rise;
   logic [N_KEYS-1:0] fall;
   logic [N_KEYS-1:0] fire;
   logic [N_KEYS-1:0] press_p;
   logic [N_KEYS-1:0] hold_p;
   logic [N_KEYS-1:0] rel_p;
   logic [N_KEYS-1:0] clr_press;
   logic [N_KEYS-1:0] clr_hold;
   logic [N_KEYS-1:0] clr_rel;
   logic [N_KEYS-1:0] loss;
   logic [CNT_W-1:0]  hold_cnt [N_KEYS];

   logic              sel_valid;
   logic [KEY_W-1:0]  sel_key;
   evt_type_e         sel_type;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [REC_W-1:0]  head;
   logic              overflow_q;

   assign rise = pbreg & ~prev;
   assign fall = ~pbreg & prev;

   // HOLD fires on the single cycle the count steps onto HOLD_CYCLES.
   always_comb begin
      fire = '0;
      for (int i = 0; i < N_KEYS; i++)
         fire[i] = pbreg[i] & ~rise[i] & (hold_cnt[i] == CNT_FIRE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
         for (int i = 0; i < N_KEYS; i++) hold_cnt[i] <= '0;
      end else begin
         prev <= pbreg;
         for (int i = 0; i < N_KEYS; i++) begin
            if (!pbreg[i] || rise[i])
               hold_cnt[i] <= '0;
            else if (hold_cnt[i] != CNT_MAX)
               hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
         end
      end
   end

   // Scan from the top so the lowest pending key index ends up selected.
   always_comb begin
      sel_valid = 1'b0;
      sel_key   = '0;
      sel_type  = EVT_NONE;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press_p[i] | hold_p[i] | rel_p[i]) begin
            sel_valid = 1'b1;
            sel_key   = KEY_W'(i);
            if (press_p[i])     sel_type = EVT_PRESS;
            else if (hold_p[i]) sel_type = EVT_HOLD;
            else                sel_type = EVT_RELEASE;
         end
      end
   end

   assign pop  = evt.evt_valid & evt.evt_ready;
   assign push = sel_valid & (~full | pop);

   always_comb begin
      clr_press = '0;
      clr_hold  = '0;
      clr_rel   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (push && (sel_key == KEY_W'(i))) begin
            clr_press[i] = (sel_type == EVT_PRESS);
            clr_hold[i]  = (sel_type == EVT_HOLD);
            clr_rel[i]   = (sel_type == EVT_RELEASE);
         end
      end
   end

   // A flag that is still pending and not leaving this cycle cannot absorb a second event.
   assign loss = (rise & press_p & ~clr_press)
               | (fire & hold_p  & ~clr_hold)
               | (fall & rel_p   & ~clr_rel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_p    <= '0;
         hold_p     <= '0;
         rel_p      <= '0;
         overflow_q <= 1'b0;
      end else begin
         press_p    <= (press_p & ~clr_press) | rise;
         hold_p     <= (hold_p  & ~clr_hold)  | fire;
         rel_p      <= (rel_p   & ~clr_rel)   | fall;
         overflow_q <= (overflow_q & ~evt.clr_overflow) | (|loss);
      end
   end

   event_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({sel_key, sel_type}),
      .full  (full),
      .pop   (pop),
      .dout  (head),
      .empty (empty)
   );

   assign evt.evt_valid = ~empty;
   assign evt.evt_key   = empty ? '0 : head[REC_W-1:EVT_TYPE_W];
   assign evt.evt_type  = empty ? 2'b00 : head[EVT_TYPE_W-1:0];
   assign evt.overflow  = overflow_q;

endmodule
